// File: rtl/traffic_ctrl_gen.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_gen
//
// Highway / country-road intersection controller. The highway rests on green.
// A waiting country car (X) gets a turn once the highway has had its minimum
// green. Country green ends when the road empties, when emg is raised, or when
// MAX_CG runs out. Every hand-over goes through a yellow and an all-red phase.
//
// Ports
//   clock    : single clock, rising-edge active
//   clear    : synchronous active-high reset (forces HG, timer 0)
//   X        : country-road car sensor, 1 = vehicle waiting/present
//   emg      : priority request, 1 = force/hold highway right-of-way
//   hwy      : highway lamp  (0 red, 1 yellow, 2 green)
//   cntry    : country lamp  (same encoding)
//   state_o  : current state code (HG=0 .. R2H=5)
//   tmr_o    : current phase timer, saturating
// -----------------------------------------------------------------------------
module traffic_ctrl_gen #(
    parameter int Y2R_DELAY = 3,
    parameter int R2G_DELAY = 2,
    parameter int MIN_HG    = 4,
    parameter int MAX_CG    = 8,
    parameter int CW        = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          X,
    input  logic          emg,
    output logic [1:0]    hwy,
    output logic [1:0]    cntry,
    output logic [2:0]    state_o,
    output logic [CW-1:0] tmr_o
);

    typedef enum logic [2:0] {
        ST_HG  = 3'd0,
        ST_HY  = 3'd1,
        ST_R2C = 3'd2,
        ST_CG  = 3'd3,
        ST_CY  = 3'd4,
        ST_R2H = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    // Timer values on which each timed phase ends (timer counts from 0).
    localparam logic [CW-1:0] YEL_LAST  = CW'(Y2R_DELAY - 1);
    localparam logic [CW-1:0] RED_LAST  = CW'(R2G_DELAY - 1);
    localparam logic [CW-1:0] HG_MIN_T  = CW'(MIN_HG - 1);
    localparam logic [CW-1:0] CG_LAST   = CW'(MAX_CG - 1);
    localparam logic [CW-1:0] TMR_MAX   = '1;

    state_t        state_reg, state_next;
    logic [CW-1:0] tmr_reg, tmr_next;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_HG;
            tmr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmr_reg   <= tmr_next;
        end
    end

    // Next state, timer and lamp decode. Lamps depend on state_reg only, so
    // X/emg never reach the lamp outputs combinationally.
    always_comb begin
        state_next = state_reg;
        hwy        = LAMP_RED;
        cntry      = LAMP_RED;

        case (state_reg)
            ST_HG: begin
                hwy = LAMP_GREEN;
                // emg blocks the exit even when the other conditions hold.
                if (X && !emg && (tmr_reg >= HG_MIN_T))
                    state_next = ST_HY;
            end
            ST_HY: begin
                hwy = LAMP_YELLOW;
                if (tmr_reg == YEL_LAST)
                    state_next = ST_R2C;
            end
            ST_R2C: begin
                if (tmr_reg == RED_LAST)
                    state_next = ST_CG;
            end
            ST_CG: begin
                cntry = LAMP_GREEN;
                if (!X || emg || (tmr_reg == CG_LAST))
                    state_next = ST_CY;
            end
            ST_CY: begin
                cntry = LAMP_YELLOW;
                if (tmr_reg == YEL_LAST)
                    state_next = ST_R2H;
            end
            ST_R2H: begin
                if (tmr_reg == RED_LAST)
                    state_next = ST_HG;
            end
            default: begin
                // Codes 6/7: all red for the one cycle before recovering to HG.
                state_next = ST_HG;
            end
        endcase

        // Any state change restarts the phase timer; otherwise saturate.
        if (state_next != state_reg)
            tmr_next = '0;
        else if (tmr_reg == TMR_MAX)
            tmr_next = tmr_reg;
        else
            tmr_next = tmr_reg + 1'b1;
    end

    assign state_o = state_reg;
    assign tmr_o   = tmr_reg;

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_traffic_ctrl_gen
//
// Directed bench for traffic_ctrl_gen. One instance uses the default timing,
// a second uses all delays = 1 to show the minimum one-cycle-per-state loop.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_ctrl_gen;

    logic       clock = 1'b0;
    logic       clear, X, emg;
    logic [1:0] hwy, cntry;
    logic [2:0] state_o;
    logic [3:0] tmr_o;

    logic       clear_f, X_f, emg_f;
    logic [1:0] hwy_f, cntry_f;
    logic [2:0] state_f;
    logic [3:0] tmr_f;

    int checks = 0;
    int errors = 0;

    localparam int HG = 0, HY = 1, R2C = 2, CG = 3, CY = 4, R2H = 5;

    traffic_ctrl_gen dut (
        .clock   (clock),
        .clear   (clear),
        .X       (X),
        .emg     (emg),
        .hwy     (hwy),
        .cntry   (cntry),
        .state_o (state_o),
        .tmr_o   (tmr_o)
    );

    traffic_ctrl_gen #(
        .Y2R_DELAY (1),
        .R2G_DELAY (1),
        .MIN_HG    (1),
        .MAX_CG    (1),
        .CW        (4)
    ) dut_fast (
        .clock   (clock),
        .clear   (clear_f),
        .X       (X_f),
        .emg     (emg_f),
        .hwy     (hwy_f),
        .cntry   (cntry_f),
        .state_o (state_f),
        .tmr_o   (tmr_f)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // Expected lamp pair for each state code, as hwy*4 + cntry.
    function automatic int lamps_for(input int code);
        case (code)
            HG:      return 2 * 4 + 0;
            HY:      return 1 * 4 + 0;
            CG:      return 0 * 4 + 2;
            CY:      return 0 * 4 + 1;
            default: return 0;
        endcase
    endfunction

    // Check the default instance sits in `code` with timer 0..len-1, one step
    // per cycle; leaves the bench one step past the phase.
    task automatic expect_phase(input string tag, input int code, input int len);
        for (int i = 0; i < len; i++) begin
            chk({tag, "_state"}, 32'(state_o), 32'(code));
            chk({tag, "_tmr"}, 32'(tmr_o), 32'(i));
            chk({tag, "_lamps"}, 32'({hwy, 2'b00} | {2'b00, cntry}), 32'(lamps_for(code)));
            step();
        end
    endtask

    initial begin
        clear = 1'b1; X = 1'b0; emg = 1'b0;
        clear_f = 1'b1; X_f = 1'b1; emg_f = 1'b0;

        // ---- Reset, X=0: HG forever, timer saturates at 15 ----
        step();
        step();
        chk("rst_state", 32'(state_o), 32'(HG));
        chk("rst_tmr", 32'(tmr_o), 32'd0);
        chk("rst_hwy", 32'(hwy), 32'd2);
        chk("rst_cntry", 32'(cntry), 32'd0);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_state", 32'(state_o), 32'(HG));
            chk("idle_tmr", 32'(tmr_o), 32'((i + 1 > 15) ? 15 : i + 1));
        end
        $display("reset/idle: state=%0d tmr=%0d", state_o, tmr_o);

        // ---- Full cycle with X held, CG ends on MAX_CG ----
        clear = 1'b1;
        step();
        clear = 1'b0;
        X = 1'b1;
        expect_phase("full_hg", HG, 4);
        expect_phase("full_hy", HY, 3);
        expect_phase("full_r2c", R2C, 2);
        expect_phase("full_cg", CG, 8);
        expect_phase("full_cy", CY, 3);
        expect_phase("full_r2h", R2H, 2);
        chk("full_back_state", 32'(state_o), 32'(HG));
        chk("full_back_tmr", 32'(tmr_o), 32'd0);
        $display("full cycle: back in state=%0d tmr=%0d", state_o, tmr_o);

        // ---- Early release: X drops on the 3rd CG cycle ----
        expect_phase("er_hg", HG, 4);
        expect_phase("er_hy", HY, 3);
        expect_phase("er_r2c", R2C, 2);
        expect_phase("er_cg", CG, 2);
        chk("er_cg3_state", 32'(state_o), 32'(CG));
        chk("er_cg3_tmr", 32'(tmr_o), 32'd2);
        X = 1'b0;
        step();
        expect_phase("er_cy", CY, 3);
        expect_phase("er_r2h", R2H, 2);
        chk("er_back_state", 32'(state_o), 32'(HG));
        chk("er_back_tmr", 32'(tmr_o), 32'd0);
        $display("early release: state=%0d tmr=%0d", state_o, tmr_o);

        // ---- Emergency holds HG, then releases straight to HY ----
        X = 1'b1;
        emg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("emg_hold_state", 32'(state_o), 32'(HG));
            step();
        end
        chk("emg_hold_tmr", 32'(tmr_o), 32'd10);
        chk("emg_hold_hwy", 32'(hwy), 32'd2);
        emg = 1'b0;
        step();
        chk("emg_rel_state", 32'(state_o), 32'(HY));
        chk("emg_rel_tmr", 32'(tmr_o), 32'd0);
        step(); step(); step();
        step(); step();
        chk("emg_cg_state", 32'(state_o), 32'(CG));
        step();
        chk("emg_cg2_tmr", 32'(tmr_o), 32'd1);
        emg = 1'b1;
        step();
        emg = 1'b0;
        chk("emg_cg_exit_state", 32'(state_o), 32'(CY));
        chk("emg_cg_exit_tmr", 32'(tmr_o), 32'd0);
        $display("emergency: state=%0d tmr=%0d", state_o, tmr_o);

        // ---- Clear on 1st R2H cycle, then on 2nd HY cycle ----
        step(); step(); step();
        chk("mid_r2h_state", 32'(state_o), 32'(R2H));
        chk("mid_r2h_tmr", 32'(tmr_o), 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("mid_r2h_clr_state", 32'(state_o), 32'(HG));
        chk("mid_r2h_clr_tmr", 32'(tmr_o), 32'd0);
        step(); step(); step(); step();
        chk("mid_hy_state", 32'(state_o), 32'(HY));
        step();
        chk("mid_hy2_tmr", 32'(tmr_o), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("mid_hy_clr_state", 32'(state_o), 32'(HG));
        chk("mid_hy_clr_tmr", 32'(tmr_o), 32'd0);
        chk("mid_hy_clr_hwy", 32'(hwy), 32'd2);
        chk("mid_hy_clr_cntry", 32'(cntry), 32'd0);
        $display("mid-phase clear: state=%0d tmr=%0d", state_o, tmr_o);

        // ---- All delays = 1: one cycle per state ----
        chk("fast_rst_state", 32'(state_f), 32'(HG));
        clear_f = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("fast_seq_state", 32'(state_f), 32'(i % 6));
            chk("fast_seq_tmr", 32'(tmr_f), 32'd0);
            chk("fast_seq_lamps", 32'({hwy_f, 2'b00} | {2'b00, cntry_f}), 32'(lamps_for(i % 6)));
        end
        $display("fast loop: state=%0d tmr=%0d", state_f, tmr_f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_gen.md
TRAFFIC_CTRL_GEN -- requirements
Module: traffic_ctrl_gen

Interface
REQ-001 Parameter Y2R_DELAY, default 3: cycles spent in each yellow state; legal range 1..2^CW-1.
REQ-002 Parameter R2G_DELAY, default 2: cycles spent in each all-red state; legal range 1..2^CW-1.
REQ-003 Parameter MIN_HG, default 4: minimum cycles of highway green before a country request is served; legal range 1..2^CW-1.
REQ-004 Parameter MAX_CG, default 8: maximum cycles of country green; legal range 1..2^CW-1.
REQ-005 Parameter CW, default 4: width of the phase timer.
REQ-006 clock  input  1  single clock; all state changes on its rising edge.
REQ-007 clear  input  1  reset; synchronous and active-high.
REQ-008 X  input  1  country-road car sensor; 1 = vehicle waiting or present.
REQ-009 emg  input  1  emergency/priority request; 1 = force or hold highway right-of-way.
REQ-010 hwy  output  2  highway lamp: 0 = red, 1 = yellow, 2 = green; 3 is never driven.
REQ-011 cntry  output  2  country lamp, same encoding as hwy.
REQ-012 state_o  output  3  current state code.
REQ-013 tmr_o  output  CW  current phase timer value.

Function
REQ-014 The state codes SHALL be HG=0, HY=1, R2C=2, CG=3, CY=4, R2H=5; codes 6 and 7 are illegal.
REQ-015 Lamp outputs SHALL decode from the state register only, with no input-to-output combinational path:
- HG: hwy=2, cntry=0
- HY: hwy=1, cntry=0
- R2C: hwy=0, cntry=0
- CG: hwy=0, cntry=2
- CY: hwy=0, cntry=1
- R2H: hwy=0, cntry=0
REQ-016 Timer behaviour:
- The timer SHALL load 0 on every edge that changes state.
- On all other edges it SHALL increment by 1, saturating at 2^CW-1.
REQ-017 Transitions out of HG:
- HG SHALL move to HY when X=1 and emg=0 and tmr>=MIN_HG-1.
- Otherwise HG SHALL stay in HG.
REQ-018 HY SHALL move to R2C when tmr==Y2R_DELAY-1, so HY lasts exactly Y2R_DELAY cycles; emg is ignored in this state.
REQ-019 R2C SHALL move to CG when tmr==R2G_DELAY-1; emg is ignored in this state.
REQ-020 Transitions out of CG:
- CG SHALL move to CY when X=0, or emg=1, or tmr==MAX_CG-1.
- Otherwise CG SHALL stay in CG.
REQ-021 CY SHALL move to R2H when tmr==Y2R_DELAY-1.
REQ-022 R2H SHALL move to HG when tmr==R2G_DELAY-1.
REQ-023 An illegal state code SHALL move to HG with tmr=0 on the next edge.
REQ-024 Priority order: clear overrides everything. When an exit condition and a hold condition apply on the same edge, the exit condition wins, except emg=1 in HG, which blocks the exit.
REQ-025 No lamp combination SHALL ever show green or yellow on both roads at once.
REQ-026 Input timing: X and emg are sampled only at rising edges; a pulse of one cycle that satisfies a condition SHALL cause the transition.

Reset
REQ-027 While clear=1 at a rising edge, the next state SHALL be state_o=0 (HG), tmr_o=0, hwy=2, cntry=0, regardless of current state.
REQ-028 Mid-phase clear: clear asserted during any phase SHALL abort that phase, including in-progress yellow and all-red intervals.
REQ-029 The first edge with clear=0 SHALL start normal timing from tmr=0 in HG.

Verification
REQ-030 Reset: clear=1 for 2 cycles, then 0, with X=0 -> HG held indefinitely; hwy=2, cntry=0; tmr_o saturates at 15.
REQ-031 Full cycle: X=1 held from the first cycle after reset, defaults in use -> the bench SHALL check each phase length:
- HG 4 cycles
- HY 3 cycles
- R2C 2 cycles
- CG 8 cycles (MAX_CG timeout)
- CY 3 cycles
- R2H 2 cycles
- then HG again, with tmr_o=0 on entry.
REQ-032 Early release: X drops to 0 on the 3rd CG cycle -> CY on the next edge; R2H follows after 3 cycles; HG follows 2 cycles later.
REQ-033 Emergency:
- emg=1 with X=1 during HG -> HG held for as long as emg=1.
- emg deasserted after 10 cycles -> HY on the next edge, because the minimum green is already satisfied.
- emg pulsed during CG with X=1 -> CY on the next edge.
REQ-034 Reset mid-operation: clear=1 on the 2nd cycle of HY, and separately on the 1st cycle of R2H -> HG with tmr_o=0 on the next edge.
REQ-035 Parameter override Y2R_DELAY=1, R2G_DELAY=1, MIN_HG=1, MAX_CG=1, X=1 held -> each state lasts exactly 1 cycle, cycling 0,1,2,3,4,5,0.
